axi4_write_master: RTL

Registered single-outstanding AXI4 write master that sits between the pipeline memory stage and the data-side AXI4 interconnect. It replaces purely combinational valid gating with a proper state machine. AW and W are handshaken independently, with each channel holding its valid until accepted. The block waits for the B response and reports completion, and optionally the error status, back to the pipeline.

---
 rtl/axi4_write_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4 write master: registers one store, drives AW and W independently, waits for B.
// Optional AXI4_WMST_ERR_CAPTURE_EN adds err_addr/err_sticky capture of the first failing store.
module axi4_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_size,
    output logic                    done,
    output logic                    err,
`ifdef AXI4_WMST_ERR_CAPTURE_EN
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_sticky,
`endif
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic [7:0]              awlen,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready; once valid
    // is raised it stays high with a stable payload until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   aw_pend, w_pend;
    logic   accept, aw_fire, w_fire, b_fire;
    logic   unused_bresp;

    assign unused_bresp = bresp[0];
    assign dbg_state    = state;
    assign awlen        = 8'd0;
    assign awburst      = 2'b01;
    assign wlast        = 1'b1;

    assign accept  = req_valid && req_ready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign b_fire  = bvalid && bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SEND;
            end
            SEND: begin
                awvalid = aw_pend;
                wvalid  = w_pend;
                // Leave once nothing is still outstanding after this cycle's handshakes.
                if (!(aw_pend && !aw_fire) && !(w_pend && !w_fire)) state_nxt = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (accept) begin
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            awaddr  <= req_addr;
            awsize  <= req_size;
            wdata   <= req_data;
            wstrb   <= req_strb;
        end else begin
            if (aw_fire) aw_pend <= 1'b0;
            if (w_fire)  w_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= b_fire;
            err  <= b_fire && bresp[1];
        end
    end

`ifdef AXI4_WMST_ERR_CAPTURE_EN
    // Only the first failing store is kept; later errors leave the record alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr   <= '0;
            err_sticky <= 1'b0;
        end else if (b_fire && bresp[1] && !err_sticky) begin
            err_addr   <= awaddr;
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule
